// File: rtl/graph_dst_pkg.sv
// graph_dst_pkg: shared definitions for the destination-vertex RAM controller.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default RAM address / word widths
//   MODE_*                  : ram_mode encodings understood by uram_read_write
//   state_t                 : controller FSM state encoding
package graph_dst_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 72;

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_UPD  = 3'b010;
  localparam logic [2:0] MODE_READ = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_UPDATE,
    ST_DRAIN,
    ST_READ,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/dst_ram_ctrl_if.sv
// dst_ram_ctrl_if: mode/address/data port of the destination-vertex URAM wrapper.
// Signals:
//   ram_mode  : operation select (MODE_* from graph_dst_pkg)
//   ram_valid : port valid
//   ram_addra / ram_dina : port A address / data
//   ram_addrb / ram_dinb : port B address / data
//   ram_douta : read data, returned a fixed latency after ram_addra
// Modports: master = controller side, slave = RAM wrapper side.
interface dst_ram_ctrl_if
  import graph_dst_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [2:0]        ram_mode;
  logic              ram_valid;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_dinb;
  logic [DATA_W-1:0] ram_douta;

  modport master (
    output ram_mode, ram_valid, ram_addra, ram_dina, ram_addrb, ram_dinb,
    input  ram_douta
  );

  modport slave (
    input  ram_mode, ram_valid, ram_addra, ram_dina, ram_addrb, ram_dinb,
    output ram_douta
  );

endinterface

// File: rtl/dst_rd_fifo.sv
// dst_rd_fifo: small synchronous FIFO holding {address, data} read-out beats.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write side (ignored when full)
//   pop, dout     : read side; dout shows the head entry whenever not empty
//   count         : current occupancy
//   full, empty   : status flags
module dst_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/dst_ram_ctrl.sv
// dst_ram_ctrl: sequencer for the destination-vertex URAM wrapper.
// Phases: INIT (bulk fill, two entries per cycle), UPDATE (accumulate stream
// with same-address hazard bubbles) + DRAIN, READ (ordered read-out through a
// small FIFO with backpressure) + FLUSH.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start_init, init_value   : begin INIT, fill value
//   start_upd, upd_*         : begin UPDATE, valid/ready update stream
//   start_read, out_*        : begin READ, valid/ready result stream
//   busy, done               : FSM not idle, one-cycle end-of-phase pulse
//   ram                      : RAM port (dst_ram_ctrl_if.master), registered
//   perf_upd_cnt, perf_stall_cnt : performance counters
// Optional feature macro: DST_RAM_CTRL_PERF_EN enables the perf counters;
// without it both perf ports are tied to zero.
module dst_ram_ctrl
  import graph_dst_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_ENTRIES = 65536,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_init,
  input  logic [DATA_W-1:0] init_value,
  input  logic              start_upd,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              upd_last,
  input  logic              start_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  dst_ram_ctrl_if.master    ram,
  output logic [31:0]       perf_upd_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FW    = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_ENTRIES - 2);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_acc;
  logic              done_q;
  logic              hazard;
  logic              upd_accept;
  logic              issue;
  logic [RD_LAT:0]   pipe_v;
  logic [ADDR_W-1:0] pipe_a [RD_LAT+1];
  logic [CW-1:0]     inflight;
  logic [CW:0]       outstanding;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_dout;
  logic              pop;

  // A beat hitting the address accepted on the previous cycle would read the
  // RAM before that write commits, so it is held off for one bubble cycle.
  assign hazard     = prev_acc && (upd_addr == prev_addr);
  assign upd_ready  = !rst && (state == ST_UPDATE) && !hazard;
  assign upd_accept = upd_valid && upd_ready;

  // Reads are only issued when every outstanding beat is guaranteed a FIFO
  // slot, which is what makes the read path immune to out_ready patterns.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue = (state == ST_READ) && !fifo_full && (outstanding < (CW+1)'(DEPTH));

  // Stage i marks a read whose address has been on the port for i cycles;
  // the last stage lines up with valid ram_douta.
  always_ff @(posedge clk) begin
    if (rst) pipe_v <= '0;
    else begin
      pipe_v[0] <= issue;
      for (int i = 1; i <= RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_a[0] <= ptr;
    for (int i = 1; i <= RD_LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  dst_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_v[RD_LAT]),
    .din   ({pipe_a[RD_LAT], ram.ram_douta}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_addr  = fifo_dout[FW-1 -: ADDR_W];
  assign out_data  = fifo_dout[DATA_W-1:0];
  assign out_last  = out_valid && (out_addr == LAST_ADDR);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  // Main sequencer; all RAM port signals are registered here. ptr is the
  // INIT pair address k in INIT and the read pointer r in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      prev_addr     <= '0;
      prev_acc      <= 1'b0;
      done_q        <= 1'b0;
      ram.ram_mode  <= MODE_IDLE;
      ram.ram_valid <= 1'b0;
      ram.ram_addra <= '0;
      ram.ram_dina  <= '0;
      ram.ram_addrb <= '0;
      ram.ram_dinb  <= '0;
    end else begin
      done_q        <= 1'b0;
      prev_acc      <= 1'b0;
      ram.ram_mode  <= MODE_IDLE;
      ram.ram_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_init) begin
            state <= ST_INIT;
            ptr   <= '0;
          end else if (start_upd) begin
            state <= ST_UPDATE;
          end else if (start_read) begin
            state <= ST_READ;
            ptr   <= '0;
          end
        end
        ST_INIT: begin
          ram.ram_mode  <= MODE_INIT;
          ram.ram_valid <= 1'b1;
          ram.ram_addra <= ptr;
          ram.ram_addrb <= ptr + ADDR_W'(1);
          ram.ram_dina  <= init_value;
          ram.ram_dinb  <= init_value;
          ptr           <= ptr + ADDR_W'(2);
          if (ptr == LAST_PAIR) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        ST_UPDATE: begin
          // Valid with mode 000 on idle cycles commits any pending write.
          ram.ram_valid <= 1'b1;
          if (upd_accept) begin
            ram.ram_mode  <= MODE_UPD;
            ram.ram_addra <= upd_addr;
            ram.ram_addrb <= upd_addr;
            ram.ram_dina  <= upd_data;
            prev_addr     <= upd_addr;
            prev_acc      <= 1'b1;
            if (upd_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          ram.ram_valid <= 1'b1;
          state         <= ST_IDLE;
          done_q        <= 1'b1;
        end
        ST_READ: begin
          if (issue) begin
            ram.ram_mode  <= MODE_READ;
            ram.ram_valid <= 1'b1;
            ram.ram_addra <= ptr;
            if (ptr == LAST_ADDR) state <= ST_FLUSH;
            else                  ptr   <= ptr + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          if (pop && out_last) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DST_RAM_CTRL_PERF_EN
  logic bubble;

  assign bubble = (state == ST_UPDATE) && upd_valid && hazard;

  // Saturating counters, cleared at the start of every update phase.
  always_ff @(posedge clk) begin
    if (rst || start_upd) begin
      perf_upd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (upd_accept && (perf_upd_cnt != '1))
        perf_upd_cnt <= perf_upd_cnt + 32'd1;
      if (bubble && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_upd_cnt   = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dst_ram_ctrl.sv
// tb_dst_ram_ctrl: self-checking bench for dst_ram_ctrl with a behavioural
// URAM model (init pair writes, accumulate on update, 1-cycle read latency).
// Build with DST_RAM_CTRL_PERF_EN defined to check the perf counters.
module tb_dst_ram_ctrl;
  import graph_dst_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NE = 16;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_init = 1'b0;
  logic [DW-1:0] init_value = '0;
  logic          start_upd = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_addr = '0;
  logic [DW-1:0] upd_data = '0;
  logic          upd_last = 1'b0;
  logic          start_read = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [31:0]   perf_upd_cnt;
  logic [31:0]   perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dst_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  dst_ram_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .NUM_ENTRIES (NE),
    .RD_LAT      (RL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_init     (start_init),
    .init_value     (init_value),
    .start_upd      (start_upd),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_addr       (upd_addr),
    .upd_data       (upd_data),
    .upd_last       (upd_last),
    .start_read     (start_read),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .ram            (ram_if),
    .perf_upd_cnt   (perf_upd_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Behavioural destination RAM.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q = '0;

  always @(posedge clk) begin
    if (ram_if.ram_valid) begin
      case (ram_if.ram_mode)
        MODE_INIT: begin
          mem[ram_if.ram_addra] <= ram_if.ram_dina;
          mem[ram_if.ram_addrb] <= ram_if.ram_dinb;
        end
        MODE_UPD:  mem[ram_if.ram_addra] <= mem[ram_if.ram_addra] + ram_if.ram_dina;
        MODE_READ: rd_q <= mem[ram_if.ram_addra];
        default: ;
      endcase
    end
  end

  assign ram_if.ram_douta = rd_q;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            exp_bubbles;
  } upd_vec_t;

  upd_vec_t      vecs [6];
  logic [DW-1:0] exp_mem [NE];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Presents one update beat and counts cycles it was held off.
  task automatic applyStimulus(input upd_vec_t v, output int bubbles, output bit accepted);
    bubbles  = 0;
    accepted = 1'b0;
    upd_addr  = v.addr;
    upd_data  = v.data;
    upd_last  = v.last;
    upd_valid = 1'b1;
    for (int c = 0; c < 8 && !accepted; c++) begin
      @(negedge clk);
      if (upd_ready) accepted = 1'b1;
      else           bubbles++;
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    upd_last  = 1'b0;
  endtask

  // INIT with a coincident start_read, which is held into INIT and must be ignored.
  task automatic doInit(input logic [DW-1:0] val);
    int n = 0;
    bit seen_done = 1'b0;
    bit read_seen = 1'b0;
    @(posedge clk); #1;
    init_value = val;
    start_init = 1'b1;
    start_read = 1'b1;
    @(posedge clk); #1;
    start_init = 1'b0;
    @(posedge clk); #1;
    start_read = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      @(negedge clk);
      if (ram_if.ram_valid && ram_if.ram_mode == MODE_INIT) begin
        checkOutput("init_addra", ram_if.ram_addra, 2*n);
        checkOutput("init_addrb", ram_if.ram_addrb, 2*n+1);
        checkOutput("init_dina", ram_if.ram_dina, val);
        checkOutput("init_dinb", ram_if.ram_dinb, val);
        n++;
      end
      if (ram_if.ram_mode == MODE_READ) read_seen = 1'b1;
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("init_cycles", n, NE/2);
    checkOutput("init_done", seen_done, 1);
    checkOutput("init_read_ignored", read_seen, 0);
    @(negedge clk);
    checkOutput("init_idle_busy", busy, 0);
    checkOutput("init_idle_valid", ram_if.ram_valid, 0);
  endtask

  // Read-out; with toggle set, out_ready follows 1-0-0-1 repeating.
  task automatic readOut(input bit toggle);
    int next_addr = 0;
    int phase = 0;
    bit seen_done = 1'b0;
    bit stalled = 1'b0;
    logic [AW-1:0] held_a = '0;
    logic [DW-1:0] held_d = '0;
    @(posedge clk); #1;
    start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      out_ready = toggle ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
      phase++;
      @(negedge clk);
      if (stalled) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_addr", out_addr, held_a);
        checkOutput("hold_data", out_data, held_d);
      end
      if (out_valid && out_ready) begin
        checkOutput("rd_addr", out_addr, next_addr);
        checkOutput($sformatf("rd_data_%0d", next_addr), out_data,
                    (next_addr < NE) ? exp_mem[next_addr] : 'x);
        checkOutput("rd_last", out_last, next_addr == NE-1);
        next_addr++;
      end
      stalled = out_valid && !out_ready;
      held_a  = out_addr;
      held_d  = out_data;
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput("rd_count", next_addr, NE);
    checkOutput("rd_done", seen_done, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  bub;
    bit  acc;
    bit  seen_done;
    int  done_cnt;
    int  exp_upd;
    int  exp_stall;

    vecs[0] = '{addr: 8'd3, data: 16'd2, last: 1'b0, exp_bubbles: 0};
    vecs[1] = '{addr: 8'd7, data: 16'd4, last: 1'b0, exp_bubbles: 0};
    vecs[2] = '{addr: 8'd3, data: 16'd1, last: 1'b0, exp_bubbles: 0};
    vecs[3] = '{addr: 8'd2, data: 16'd1, last: 1'b0, exp_bubbles: 0};
    vecs[4] = '{addr: 8'd2, data: 16'd1, last: 1'b0, exp_bubbles: 1};
    vecs[5] = '{addr: 8'd2, data: 16'd1, last: 1'b1, exp_bubbles: 1};
`ifdef DST_RAM_CTRL_PERF_EN
    exp_upd   = 6;
    exp_stall = 2;
`else
    exp_upd   = 0;
    exp_stall = 0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mode", ram_if.ram_mode, MODE_IDLE);
    checkOutput("rst_valid", ram_if.ram_valid, 0);
    checkOutput("rst_addra", ram_if.ram_addra, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_upd_ready", upd_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_perf_upd", perf_upd_cnt, 0);

    // Init to 5, then read back with out_ready held high
    doInit(16'd5);
    for (int i = 0; i < NE; i++) exp_mem[i] = 16'd5;
    readOut(1'b0);

    // Init to 0, update table, then read back under toggling backpressure
    doInit(16'd0);
    @(posedge clk); #1 start_upd = 1'b1;
    @(posedge clk); #1 start_upd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], bub, acc);
      checkOutput($sformatf("upd_accept_%0d", i), acc, 1);
      checkOutput($sformatf("upd_bubbles_%0d", i), bub, vecs[i].exp_bubbles);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("upd_done", seen_done, 1);
    checkOutput("perf_upd", perf_upd_cnt, exp_upd);
    checkOutput("perf_stall", perf_stall_cnt, exp_stall);
    for (int i = 0; i < NE; i++) exp_mem[i] = 16'd0;
    exp_mem[2] = 16'd3;
    exp_mem[3] = 16'd3;
    exp_mem[7] = 16'd4;
    readOut(1'b1);

    // Reset in the middle of an update phase
    @(posedge clk); #1 start_upd = 1'b1;
    @(posedge clk); #1 start_upd = 1'b0;
    applyStimulus('{addr: 8'd5, data: 16'd1, last: 1'b0, exp_bubbles: 0}, bub, acc);
    checkOutput("abort_accept", acc, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_mode", ram_if.ram_mode, MODE_IDLE);
    checkOutput("abort_valid", ram_if.ram_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_upd_ready", upd_ready, 0);
    checkOutput("abort_perf_upd", perf_upd_cnt, 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", done_cnt, 0);
    doInit(16'd9);
    for (int i = 0; i < NE; i++) exp_mem[i] = 16'd9;
    readOut(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
